// File: rtl/emc_prog_mem_ctrl.sv
// Program-memory fetch sequencer: serves CPU byte fetches from the internal
// ROM or via an 8051-style multiplexed P0/P2 external bus cycle.
//
// state    | meaning
// IDLE     | waiting for a fetch request; address captured on accept
// INT_RD   | ROM chip select asserted for one cycle
// EXT_ADDR | ALE high, address driven on P0/P2
// EXT_STRB | PSEN_B low for EXT_WAIT cycles, P0 released, P2 held
// DONE     | ack pulse with fetched byte, strobes released
module emc_prog_mem_ctrl #(
  parameter int ROM_AW   = 12,
  parameter int EXT_WAIT = 2
) (
  input  logic              pmc_clock_i,
  input  logic              pmc_reset_i,
  input  logic              pmc_ea_b_i,
  input  logic              pmc_req_i,
  input  logic [15:0]       pmc_addr_i,
  output logic              pmc_ack_o,
  output logic [7:0]        pmc_data_o,
  output logic              pmc_busy_o,
  output logic              pmc_rom_cs_o,
  output logic [ROM_AW-1:0] pmc_rom_addr_o,
  input  logic [7:0]        pmc_rom_data_i,
  output logic [7:0]        pmc_p0_a_o,
  output logic [7:0]        pmc_p0_en_o,
  input  logic [7:0]        pmc_p0_y_i,
  output logic [7:0]        pmc_p2_a_o,
  output logic [7:0]        pmc_p2_en_o,
  output logic              pmc_ale_o,
  output logic              pmc_psen_b_o
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    INT_RD   = 3'd1,
    EXT_ADDR = 3'd2,
    EXT_STRB = 3'd3,
    DONE     = 3'd4
  } state_t;

  localparam logic [3:0] WAIT_LOAD = 4'(EXT_WAIT - 1);

  state_t      state, state_nxt;
  logic [15:0] addr_q, addr_nxt;
  logic [3:0]  wait_cnt, wait_cnt_nxt;
  logic [7:0]  data_q, data_nxt;
  logic        in_window;

  assign in_window = (({16'h0000, pmc_addr_i} >> ROM_AW) == 32'd0);

  always_ff @(posedge pmc_clock_i or negedge pmc_reset_i) begin
    if (!pmc_reset_i) begin
      state    <= IDLE;
      addr_q   <= 16'h0000;
      wait_cnt <= 4'd0;
      data_q   <= 8'h00;
    end else begin
      state    <= state_nxt;
      addr_q   <= addr_nxt;
      wait_cnt <= wait_cnt_nxt;
      data_q   <= data_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    addr_nxt     = addr_q;
    wait_cnt_nxt = wait_cnt;
    data_nxt     = data_q;
    case (state)
      IDLE: begin
        if (pmc_req_i) begin
          addr_nxt  = pmc_addr_i;
          state_nxt = (pmc_ea_b_i && in_window) ? INT_RD : EXT_ADDR;
        end
      end
      INT_RD: begin
        data_nxt  = pmc_rom_data_i;
        state_nxt = DONE;
      end
      EXT_ADDR: begin
        wait_cnt_nxt = WAIT_LOAD;
        state_nxt    = EXT_STRB;
      end
      EXT_STRB: begin
        if (wait_cnt == 4'd0) begin
          data_nxt  = pmc_p0_y_i;
          state_nxt = DONE;
        end else begin
          wait_cnt_nxt = wait_cnt - 4'd1;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decode only from registered state so reset forces them at once.
  assign pmc_ack_o      = (state == DONE);
  assign pmc_busy_o     = (state != IDLE);
  assign pmc_data_o     = data_q;
  assign pmc_rom_cs_o   = (state == INT_RD);
  assign pmc_rom_addr_o = addr_q[ROM_AW-1:0];
  assign pmc_ale_o      = (state == EXT_ADDR);
  assign pmc_p0_a_o     = (state == EXT_ADDR) ? addr_q[7:0] : 8'h00;
  assign pmc_p0_en_o    = (state == EXT_ADDR) ? 8'hFF : 8'h00;
  assign pmc_p2_a_o     = (state == EXT_ADDR || state == EXT_STRB) ? addr_q[15:8] : 8'h00;
  assign pmc_p2_en_o    = (state == EXT_ADDR || state == EXT_STRB) ? 8'hFF : 8'h00;
  assign pmc_psen_b_o   = (state != EXT_STRB);

endmodule

// File: tb/tb_emc_prog_mem_ctrl.sv
// Directed bench for emc_prog_mem_ctrl: internal, boundary, external,
// mid-transaction reset and request-drop fetches with hand-computed values.
module tb_emc_prog_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ea_b = 1'b1;
  logic        req = 1'b0;
  logic [15:0] addr = 16'h0000;
  logic        ack;
  logic [7:0]  data;
  logic        busy;
  logic        rom_cs;
  logic [11:0] rom_addr;
  logic [7:0]  rom_data = 8'h00;
  logic [7:0]  p0_a, p0_en, p2_a, p2_en;
  logic [7:0]  p0_y = 8'h00;
  logic        ale, psen_b;

  int checks = 0;
  int failures = 0;
  int ack_cnt;
  int busy_cnt;

  always #5 clk = ~clk;

  emc_prog_mem_ctrl #(.ROM_AW(12), .EXT_WAIT(2)) dut (
    .pmc_clock_i    (clk),
    .pmc_reset_i    (rst_n),
    .pmc_ea_b_i     (ea_b),
    .pmc_req_i      (req),
    .pmc_addr_i     (addr),
    .pmc_ack_o      (ack),
    .pmc_data_o     (data),
    .pmc_busy_o     (busy),
    .pmc_rom_cs_o   (rom_cs),
    .pmc_rom_addr_o (rom_addr),
    .pmc_rom_data_i (rom_data),
    .pmc_p0_a_o     (p0_a),
    .pmc_p0_en_o    (p0_en),
    .pmc_p0_y_i     (p0_y),
    .pmc_p2_a_o     (p2_a),
    .pmc_p2_en_o    (p2_en),
    .pmc_ale_o      (ale),
    .pmc_psen_b_o   (psen_b)
  );

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic e, input logic [15:0] a);
    ea_b = e;
    addr = a;
    req  = 1'b1;
  endtask

  initial begin
    // reset held
    @(negedge clk);
    chk("rst_psen_b", 16'(psen_b), 16'h1);
    chk("rst_p0_en", 16'(p0_en), 16'h00);
    chk("rst_p2_en", 16'(p2_en), 16'h00);
    @(negedge clk);
    chk("rst_ack", 16'(ack), 16'h0);
    chk("rst_busy", 16'(busy), 16'h0);
    chk("rst_data", 16'(data), 16'h00);
    chk("rst_rom_cs", 16'(rom_cs), 16'h0);
    chk("rst_rom_addr", 16'(rom_addr), 16'h000);
    chk("rst_ale", 16'(ale), 16'h0);
    chk("rst_p0_a", 16'(p0_a), 16'h00);
    chk("rst_p2_a", 16'(p2_a), 16'h00);
    chk("rst_psen_b2", 16'(psen_b), 16'h1);
    rst_n = 1'b1;
    @(negedge clk);

    // internal fetch 0x0123
    rom_data = 8'hA5;
    issue(1'b1, 16'h0123);
    @(negedge clk);
    chk("int_rom_cs", 16'(rom_cs), 16'h1);
    chk("int_rom_addr", 16'(rom_addr), 16'h123);
    chk("int_busy", 16'(busy), 16'h1);
    chk("int_psen_b", 16'(psen_b), 16'h1);
    chk("int_ack_early", 16'(ack), 16'h0);
    @(negedge clk);
    chk("int_ack", 16'(ack), 16'h1);
    chk("int_data", 16'(data), 16'hA5);
    chk("int_rom_cs_off", 16'(rom_cs), 16'h0);
    req = 1'b0;
    rom_data = 8'h00;
    @(negedge clk);
    chk("int_ack_off", 16'(ack), 16'h0);
    chk("int_idle", 16'(busy), 16'h0);
    chk("int_data_hold", 16'(data), 16'hA5);

    // boundary: last internal address
    rom_data = 8'h77;
    issue(1'b1, 16'h0FFF);
    @(negedge clk);
    chk("bnd_fff_rom_cs", 16'(rom_cs), 16'h1);
    chk("bnd_fff_rom_addr", 16'(rom_addr), 16'hFFF);
    chk("bnd_fff_ale", 16'(ale), 16'h0);
    @(negedge clk);
    chk("bnd_fff_ack", 16'(ack), 16'h1);
    chk("bnd_fff_data", 16'(data), 16'h77);
    req = 1'b0;
    @(negedge clk);

    // boundary: first external address
    p0_y = 8'h99;
    issue(1'b1, 16'h1000);
    @(negedge clk);
    chk("bnd_1000_ale", 16'(ale), 16'h1);
    chk("bnd_1000_rom_cs", 16'(rom_cs), 16'h0);
    chk("bnd_1000_p0_a", 16'(p0_a), 16'h00);
    chk("bnd_1000_p2_a", 16'(p2_a), 16'h10);
    chk("bnd_1000_p0_en", 16'(p0_en), 16'hFF);
    chk("bnd_1000_p2_en", 16'(p2_en), 16'hFF);
    chk("bnd_1000_psen_a", 16'(psen_b), 16'h1);
    @(negedge clk);
    chk("bnd_1000_psen_s1", 16'(psen_b), 16'h0);
    chk("bnd_1000_ale_s1", 16'(ale), 16'h0);
    chk("bnd_1000_p0_en_s1", 16'(p0_en), 16'h00);
    chk("bnd_1000_p2_a_s1", 16'(p2_a), 16'h10);
    chk("bnd_1000_p2_en_s1", 16'(p2_en), 16'hFF);
    chk("bnd_1000_ack_s1", 16'(ack), 16'h0);
    @(negedge clk);
    chk("bnd_1000_psen_s2", 16'(psen_b), 16'h0);
    chk("bnd_1000_ack_s2", 16'(ack), 16'h0);
    @(negedge clk);
    chk("bnd_1000_ack", 16'(ack), 16'h1);
    chk("bnd_1000_data", 16'(data), 16'h99);
    chk("bnd_1000_psen_d", 16'(psen_b), 16'h1);
    chk("bnd_1000_p2_en_d", 16'(p2_en), 16'h00);
    req = 1'b0;
    @(negedge clk);

    // 0xFFFF is external even with ea_b=1
    p0_y = 8'h5E;
    issue(1'b1, 16'hFFFF);
    @(negedge clk);
    chk("ffff_ale", 16'(ale), 16'h1);
    chk("ffff_p0_a", 16'(p0_a), 16'hFF);
    chk("ffff_p2_a", 16'(p2_a), 16'hFF);
    repeat (3) @(negedge clk);
    chk("ffff_ack", 16'(ack), 16'h1);
    chk("ffff_data", 16'(data), 16'h5E);
    req = 1'b0;
    @(negedge clk);

    // ea_b=0 forces external, p0_y=0x3C
    p0_y = 8'h3C;
    rom_data = 8'hEE;
    issue(1'b0, 16'h0042);
    @(negedge clk);
    chk("frc_rom_cs", 16'(rom_cs), 16'h0);
    chk("frc_ale", 16'(ale), 16'h1);
    chk("frc_p0_a", 16'(p0_a), 16'h42);
    chk("frc_p2_a", 16'(p2_a), 16'h00);
    chk("frc_p0_en_a", 16'(p0_en), 16'hFF);
    @(negedge clk);
    chk("frc_p0_en_s", 16'(p0_en), 16'h00);
    chk("frc_psen_s", 16'(psen_b), 16'h0);
    chk("frc_rom_cs_s", 16'(rom_cs), 16'h0);
    @(negedge clk);
    chk("frc_ack_s2", 16'(ack), 16'h0);
    @(negedge clk);
    chk("frc_ack", 16'(ack), 16'h1);
    chk("frc_data", 16'(data), 16'h3C);
    req = 1'b0;
    @(negedge clk);
    chk("frc_p2_en_after", 16'(p2_en), 16'h00);
    chk("frc_ack_after", 16'(ack), 16'h0);
    chk("frc_busy_after", 16'(busy), 16'h0);

    // reset in EXT_STRB
    p0_y = 8'hC7;
    issue(1'b1, 16'h8421);
    @(negedge clk);
    @(negedge clk);
    chk("mrst_in_strb", 16'(psen_b), 16'h0);
    rst_n = 1'b0;
    req   = 1'b0;
    #1;
    chk("mrst_psen_b", 16'(psen_b), 16'h1);
    chk("mrst_p2_en", 16'(p2_en), 16'h00);
    chk("mrst_busy", 16'(busy), 16'h0);
    chk("mrst_data", 16'(data), 16'h00);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    ack_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (ack) ack_cnt++;
    end
    chk("mrst_no_ack", 16'(ack_cnt), 16'd0);

    rom_data = 8'h5C;
    issue(1'b1, 16'h0010);
    @(negedge clk);
    chk("mrst_next_rom_cs", 16'(rom_cs), 16'h1);
    @(negedge clk);
    chk("mrst_next_ack", 16'(ack), 16'h1);
    chk("mrst_next_data", 16'(data), 16'h5C);
    req = 1'b0;
    @(negedge clk);

    // req dropped and ea_b flipped during EXT_STRB
    p0_y = 8'hE1;
    issue(1'b1, 16'h2345);
    @(negedge clk);
    chk("drop_ale", 16'(ale), 16'h1);
    @(negedge clk);
    req  = 1'b0;
    ea_b = 1'b0;
    addr = 16'h0000;
    ack_cnt = 0;
    @(negedge clk);
    chk("drop_psen", 16'(psen_b), 16'h0);
    chk("drop_p2_a", 16'(p2_a), 16'h23);
    @(negedge clk);
    chk("drop_ack", 16'(ack), 16'h1);
    chk("drop_data", 16'(data), 16'hE1);
    if (ack) ack_cnt++;
    busy_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (ack) ack_cnt++;
      if (busy) busy_cnt++;
    end
    chk("drop_ack_once", 16'(ack_cnt), 16'd1);
    chk("drop_no_restart", 16'(busy_cnt), 16'd0);
    chk("drop_data_hold", 16'(data), 16'hE1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
